attn_seq_ctrl: RTL and testbench

- Instruction sequencer for the fullchip QK-attention datapath.
- Host loads Qmem/Kmem itself through a pass-through instruction port, then pulses start.
- The block then drives the 20-bit fullchip inst word through these phases: K load, Q execute, OFIFO-to-pmem move, and per-row SFP normalize.
- Sits directly in front of fullchip.inst and replaces hand-sequenced control.

---
 rtl/attn_seq_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_attn_seq_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/attn_seq_ctrl.sv
// attn_seq_ctrl: instruction sequencer for the fullchip QK-attention datapath.
// While idle the host word is passed straight through to inst so the host can
// fill Qmem/Kmem itself. A start pulse then runs, without further host help:
// K load, Q execute, OFIFO-to-pmem move, and a four-step SFP normalize per row.
// Each inst word is computed from the next state and registered, so the word
// for a state is on inst during the cycle that follows the edge entering it.
// Optional feature macro: ATTN_SEQ_PERF_EN (busy-cycle and MOVE-stall counters).
// Reset: asynchronous, active low on 'reset'.

module attn_seq_ctrl #(
    parameter int col         = 8,   // K rows loaded, 1..16
    parameter int total_cycle = 8,   // Q vectors / pmem rows, 1..16
    parameter int gap         = 10   // idle cycles after load and execute, 0..255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [19:0] host_inst,
    input  logic        ofifo_valid,
    output logic [19:0] inst,
    output logic        busy,
    output logic        done,
    output logic [15:0] perf_cycles,
    output logic [15:0] perf_stalls
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LOAD  = 4'd1,
        S_LEND1 = 4'd2,
        S_LEND2 = 4'd3,
        S_GAP1  = 4'd4,
        S_EXEC  = 4'd5,
        S_XEND  = 4'd6,
        S_GAP2  = 4'd7,
        S_MOVE  = 4'd8,
        S_NORM  = 4'd9,
        S_DONE  = 4'd10
    } state_t;

    localparam logic [7:0] COL_C       = 8'(col);
    localparam logic [7:0] TC_C        = 8'(total_cycle);
    localparam logic [7:0] GAP_C       = 8'(gap);
    localparam logic [7:0] GAP_LAST_C  = 8'(gap - 1);
    localparam logic [7:0] TC_LAST_C   = 8'(total_cycle - 1);
    // NORM counts row*4+sub, so the last word sits at 4*total_cycle-1.
    localparam logic [7:0] NORM_LAST_C = 8'(4 * total_cycle - 1);

    state_t      state_r;
    state_t      state_n;
    logic [7:0]  cnt_r;       // phase index; in MOVE it is rows already issued
    logic [7:0]  cnt_n;
    logic        abort_s;     // abort accepted in a busy state
    logic        move_issue_s;
    logic [3:0]  move_row_s;
    logic [3:0]  load_add_s;
    logic [19:0] word_s;
    logic        busy_s;
    logic        done_s;
    logic [19:0] inst_r;
    logic        busy_r;
    logic        done_r;

    // State and phase counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
    end

    // Next-state and counter decode; MOVE only advances its row when OFIFO has data.
    always_comb begin
        state_n      = state_r;
        cnt_n        = cnt_r;
        abort_s      = 1'b0;
        move_issue_s = 1'b0;
        move_row_s   = 4'd0;
        if (abort && (state_r != S_IDLE) && (state_r != S_DONE)) begin
            abort_s = 1'b1;
            state_n = S_IDLE;
            cnt_n   = 8'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    cnt_n = 8'd0;
                    if (start && !abort) begin
                        state_n = S_LOAD;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (cnt_r == COL_C) begin
                        state_n = S_LEND1;
                        cnt_n   = 8'd0;
                    end else begin
                        cnt_n = cnt_r + 8'd1;
                    end
                end
                S_LEND1: begin
                    state_n = S_LEND2;
                    cnt_n   = 8'd0;
                end
                S_LEND2: begin
                    cnt_n = 8'd0;
                    if (GAP_C == 8'd0) begin
                        state_n = S_EXEC;
                    end else begin
                        state_n = S_GAP1;
                    end
                end
                S_GAP1: begin
                    if (cnt_r == GAP_LAST_C) begin
                        state_n = S_EXEC;
                        cnt_n   = 8'd0;
                    end else begin
                        cnt_n = cnt_r + 8'd1;
                    end
                end
                S_EXEC: begin
                    if (cnt_r == TC_LAST_C) begin
                        state_n = S_XEND;
                        cnt_n   = 8'd0;
                    end else begin
                        cnt_n = cnt_r + 8'd1;
                    end
                end
                S_XEND: begin
                    if (GAP_C == 8'd0) begin
                        state_n      = S_MOVE;
                        move_issue_s = ofifo_valid;
                        cnt_n        = {7'd0, ofifo_valid};
                    end else begin
                        state_n = S_GAP2;
                        cnt_n   = 8'd0;
                    end
                end
                S_GAP2: begin
                    if (cnt_r == GAP_LAST_C) begin
                        state_n      = S_MOVE;
                        move_issue_s = ofifo_valid;
                        cnt_n        = {7'd0, ofifo_valid};
                    end else begin
                        cnt_n = cnt_r + 8'd1;
                    end
                end
                S_MOVE: begin
                    if (cnt_r == TC_C) begin
                        state_n = S_NORM;
                        cnt_n   = 8'd0;
                    end else begin
                        move_row_s   = cnt_r[3:0];
                        move_issue_s = ofifo_valid;
                        cnt_n        = cnt_r + {7'd0, ofifo_valid};
                    end
                end
                S_NORM: begin
                    if (cnt_r == NORM_LAST_C) begin
                        state_n = S_DONE;
                        cnt_n   = 8'd0;
                    end else begin
                        cnt_n = cnt_r + 8'd1;
                    end
                end
                S_DONE: begin
                    state_n = S_IDLE;
                    cnt_n   = 8'd0;
                end
                default: begin
                    state_n = S_IDLE;
                    cnt_n   = 8'd0;
                end
            endcase
        end
    end

    // LOAD address is cnt-1 from cnt=2 on; the 4-bit wrap gives 15 when col=16.
    assign load_add_s = cnt_n[3:0] - 4'd1;

    // Instruction word and status for the state being entered.
    always_comb begin
        word_s = 20'd0;
        case (state_n)
            S_IDLE: begin
                if (abort_s) begin
                    word_s = 20'd0;
                end else begin
                    word_s = host_inst;
                end
            end
            S_LOAD: begin
                word_s[6] = 1'b1;
                if (cnt_n >= 8'd1) begin
                    word_s[3] = 1'b1;
                end else begin
                    word_s[3] = 1'b0;
                end
                if (cnt_n >= 8'd2) begin
                    word_s[15:12] = load_add_s;
                end else begin
                    word_s[15:12] = 4'd0;
                end
            end
            S_LEND1: begin
                word_s[6] = 1'b1;
            end
            S_EXEC: begin
                word_s[7]     = 1'b1;
                word_s[5]     = 1'b1;
                word_s[15:12] = cnt_n[3:0];
            end
            S_MOVE: begin
                if (move_issue_s) begin
                    word_s[16]   = 1'b1;
                    word_s[0]    = 1'b1;
                    word_s[11:8] = move_row_s;
                end else begin
                    word_s = 20'd0;
                end
            end
            S_NORM: begin
                word_s[11:8] = cnt_n[5:2];
                case (cnt_n[1:0])
                    2'd0:    word_s[1]  = 1'b1;
                    2'd1:    word_s[18] = 1'b1;
                    2'd2:    word_s[17] = 1'b1;
                    2'd3: begin
                        word_s[19] = 1'b1;
                        word_s[0]  = 1'b1;
                    end
                    default: word_s = 20'd0;
                endcase
            end
            default: begin
                word_s = 20'd0;
            end
        endcase
        busy_s = (state_n != S_IDLE) && (state_n != S_DONE);
        done_s = (state_n == S_DONE);
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_r <= 20'd0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            inst_r <= word_s;
            busy_r <= busy_s;
            done_r <= done_s;
        end
    end

    assign inst = inst_r;
    assign busy = busy_r;
    assign done = done_r;

`ifdef ATTN_SEQ_PERF_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    logic        start_acc_s;
    logic        stall_s;
    logic        stall_r;      // the word on inst now is a MOVE stall
    logic [15:0] perf_cycles_r;
    logic [15:0] perf_stalls_r;

    assign start_acc_s = (state_r == S_IDLE) && start && !abort;
    assign stall_s     = (state_n == S_MOVE) && !move_issue_s;

    // Counters count cycles whose presented outputs were busy / stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_r       <= 1'b0;
            perf_cycles_r <= 16'd0;
            perf_stalls_r <= 16'd0;
        end else begin
            stall_r <= stall_s;
            if (start_acc_s) begin
                perf_cycles_r <= 16'd0;
                perf_stalls_r <= 16'd0;
            end else begin
                if (busy_r) begin
                    perf_cycles_r <= sat_inc16(perf_cycles_r);
                end else begin
                    perf_cycles_r <= perf_cycles_r;
                end
                if (stall_r) begin
                    perf_stalls_r <= sat_inc16(perf_stalls_r);
                end else begin
                    perf_stalls_r <= perf_stalls_r;
                end
            end
        end
    end

    assign perf_cycles = perf_cycles_r;
    assign perf_stalls = perf_stalls_r;
`else
    assign perf_cycles = 16'd0;
    assign perf_stalls = 16'd0;
`endif

endmodule

// File: tb/tb_attn_seq_ctrl.sv
// Scoreboard bench for attn_seq_ctrl. Two instances share all inputs:
// dut0 with default parameters, dut1 with col=16, total_cycle=16, gap=0.
// The reference model expands each accepted start into the planned list of
// inst words; a MOVE word is held (all-zero word shown) while ofifo_valid=0.
module tb_attn_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [19:0] host_inst;
    logic        ofifo_valid;
    logic [19:0] inst0, inst1;
    logic        busy0, busy1, done0, done1;
    logic [15:0] pc0, pc1, ps0, ps1;

    always #5 clk = ~clk;

    attn_seq_ctrl #(.col(8), .total_cycle(8), .gap(10)) dut0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .host_inst(host_inst), .ofifo_valid(ofifo_valid),
        .inst(inst0), .busy(busy0), .done(done0),
        .perf_cycles(pc0), .perf_stalls(ps0)
    );

    attn_seq_ctrl #(.col(16), .total_cycle(16), .gap(0)) dut1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .host_inst(host_inst), .ofifo_valid(ofifo_valid),
        .inst(inst1), .busy(busy1), .done(done1),
        .perf_cycles(pc1), .perf_stalls(ps1)
    );

    typedef struct packed {
        logic [19:0] inst;
        logic        busy;
        logic        done;
        logic [15:0] pc;
        logic [15:0] ps;
    } exp_t;

    exp_t        expq [2][$];
    logic [20:0] plan [2][$];   // bit 20 marks a MOVE word
    int          col_p [2] = '{8, 16};
    int          tc_p  [2] = '{8, 16};
    int          gap_p [2] = '{10, 0};
    bit          running [2];
    bit          done_pend [2];
    bit          prev_busy [2];
    bit          prev_stall [2];
    logic [15:0] pc_m [2];
    logic [15:0] ps_m [2];
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            plan[d].delete();
            expq[d].delete();
            running[d]    = 1'b0;
            done_pend[d]  = 1'b0;
            prev_busy[d]  = 1'b0;
            prev_stall[d] = 1'b0;
            pc_m[d]       = 16'd0;
            ps_m[d]       = 16'd0;
        end
    endtask

    task automatic build_plan(input int d);
        logic [20:0] w;
        plan[d].delete();
        for (int c = 0; c <= col_p[d]; c++) begin
            w = 21'd0; w[6] = 1'b1;
            if (c >= 1) w[3] = 1'b1;
            if (c >= 2) w[15:12] = 4'(c - 1);
            plan[d].push_back(w);
        end
        w = 21'd0; w[6] = 1'b1; plan[d].push_back(w);
        plan[d].push_back(21'd0);
        for (int g = 0; g < gap_p[d]; g++) plan[d].push_back(21'd0);
        for (int r = 0; r < tc_p[d]; r++) begin
            w = 21'd0; w[7] = 1'b1; w[5] = 1'b1; w[15:12] = 4'(r);
            plan[d].push_back(w);
        end
        plan[d].push_back(21'd0);
        for (int g = 0; g < gap_p[d]; g++) plan[d].push_back(21'd0);
        for (int r = 0; r < tc_p[d]; r++) begin
            w = 21'd0; w[20] = 1'b1; w[16] = 1'b1; w[0] = 1'b1; w[11:8] = 4'(r);
            plan[d].push_back(w);
        end
        for (int r = 0; r < tc_p[d]; r++) begin
            for (int k = 0; k < 4; k++) begin
                w = 21'd0; w[11:8] = 4'(r);
                if (k == 0) w[1] = 1'b1;
                if (k == 1) w[18] = 1'b1;
                if (k == 2) w[17] = 1'b1;
                if (k == 3) begin w[19] = 1'b1; w[0] = 1'b1; end
                plan[d].push_back(w);
            end
        end
    endtask

    // Expected outputs after the next active edge, given the inputs at that edge.
    task automatic model_step(input int d, input bit s, input bit a,
                              input logic [19:0] h, input bit ov, output exp_t e);
        bit          stall;
        logic [20:0] w;
        e = '0;
        stall = 1'b0;
        if (done_pend[d]) begin
            done_pend[d] = 1'b0;
            e.inst = h;
        end else if (running[d]) begin
            if (a) begin
                plan[d].delete();
                running[d] = 1'b0;
            end else if (plan[d].size() == 0) begin
                e.done = 1'b1;
                running[d] = 1'b0;
                done_pend[d] = 1'b1;
            end else begin
                w = plan[d][0];
                e.busy = 1'b1;
                if (w[20] && !ov) begin
                    stall = 1'b1;
                end else begin
                    w = plan[d].pop_front();
                    e.inst = w[19:0];
                end
            end
        end else if (s && !a) begin
            build_plan(d);
            running[d]    = 1'b1;
            pc_m[d]       = 16'd0;
            ps_m[d]       = 16'd0;
            prev_busy[d]  = 1'b0;
            prev_stall[d] = 1'b0;
            w = plan[d].pop_front();
            e.inst = w[19:0];
            e.busy = 1'b1;
        end else begin
            e.inst = h;
        end
        if (prev_busy[d])  pc_m[d] = sat_inc(pc_m[d]);
        if (prev_stall[d]) ps_m[d] = sat_inc(ps_m[d]);
        prev_busy[d]  = e.busy;
        prev_stall[d] = stall;
`ifdef ATTN_SEQ_PERF_EN
        e.pc = pc_m[d];
        e.ps = ps_m[d];
`else
        e.pc = 16'd0;
        e.ps = 16'd0;
`endif
    endtask

    task automatic drive(input bit s, input bit a, input logic [19:0] h, input bit ov);
        exp_t e;
        start = s; abort = a; host_inst = h; ofifo_valid = ov;
        for (int d = 0; d < 2; d++) begin
            model_step(d, s, a, h, ov, e);
            expq[d].push_back(e);
        end
    endtask

    task automatic tick(input bit s, input bit a, input logic [19:0] h, input bit ov);
        @(negedge clk);
        drive(s, a, h, ov);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", nm, act, act, req, req);
        end
    endtask

    task automatic cmp_exp(input int d, input exp_t act, input exp_t e);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL scoreboard dut%0d t=%0t: got inst=%h busy=%b done=%b pc=%0d ps=%0d expected inst=%h busy=%b done=%b pc=%0d ps=%0d",
                     d, $time, act.inst, act.busy, act.done, act.pc, act.ps,
                     e.inst, e.busy, e.done, e.pc, e.ps);
        end
    endtask

    // Monitor: compare each presented output against the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (expq[0].size() > 0) cmp_exp(0, {inst0, busy0, done0, pc0, ps0}, expq[0].pop_front());
        if (expq[1].size() > 0) cmp_exp(1, {inst1, busy1, done1, pc1, ps1}, expq[1].pop_front());
    end

    // Tick i carries start when i==1; returns the tick index at which done rose.
    task automatic run_seq(input int stall_at, input int abort_at, input int maxc,
                           output int slot0, output int slot1);
        bit ov;
        slot0 = -1;
        slot1 = -1;
        for (int i = 1; i <= maxc; i++) begin
            ov = !(stall_at != 0 && i >= stall_at && i < stall_at + 3);
            tick(i == 1, i == abort_at, 20'($urandom), ov);
            @(posedge clk); #2;
            if (done0 && slot0 < 0) slot0 = i;
            if (done1 && slot1 < 0) slot1 = i;
            if (slot0 >= 0 && slot1 >= 0) break;
        end
    endtask

    initial begin
        int s0, s1;
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        host_inst = 20'd0; ofifo_valid = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_inst0", {12'd0, inst0}, 32'd0);
        chk("rst_busy0", {31'd0, busy0}, 32'd0);
        chk("rst_done0", {31'd0, done0}, 32'd0);
        chk("rst_perf0", {pc0, ps0}, 32'd0);
        chk("rst_inst1", {12'd0, inst1}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 20'h00010, 1'b1);
        @(posedge clk); #2;
        chk("passthru_inst", {12'd0, inst0}, 32'h00010);
        chk("passthru_busy", {31'd0, busy0}, 32'd0);
        // abort wins over start in IDLE
        tick(1'b1, 1'b1, 20'h12345, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 20'($urandom), 1'b1);

        // full run, no stalls
        run_seq(0, 0, 200, s0, s1);
        chk("done_slot_default", s0, 81);
        chk("done_slot_big", s1, 117);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 20'($urandom), 1'b1);

        // MOVE stall of three cycles at dut0 row 2
        run_seq(43, 0, 200, s0, s1);
        chk("done_slot_stall0", s0, 84);
        chk("done_slot_stall1", s1, 120);
`ifdef ATTN_SEQ_PERF_EN
        chk("perf_cycles0", {16'd0, pc0}, 83);
        chk("perf_stalls0", {16'd0, ps0}, 3);
        chk("perf_cycles1", {16'd0, pc1}, 119);
        chk("perf_stalls1", {16'd0, ps1}, 3);
`else
        chk("perf_off", {pc0 | pc1, ps0 | ps1}, 32'd0);
`endif
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 20'($urandom), 1'b1);

        // abort while dut0 executes row 4, restart two cycles later
        run_seq(0, 27, 28, s0, s1);
        chk("abort_no_done", s0, -1);
        chk("abort_busy", {31'd0, busy0}, 32'd0);
        run_seq(0, 0, 200, s0, s1);
        chk("restart_done_slot", s0, 81);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 20'($urandom), 1'b1);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            tick($urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0,
                 20'($urandom), $urandom_range(0, 4) != 0);
        end
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 20'($urandom), 1'b1);

        // asynchronous reset in the middle of dut0 NORM
        for (int i = 1; i <= 60; i++) tick(i == 1, 1'b0, 20'($urandom), 1'b1);
        @(posedge clk); #3;
        reset = 1'b0;
        model_reset();
        #1;
        chk("async_rst_inst0", {12'd0, inst0}, 32'd0);
        chk("async_rst_busy0", {31'd0, busy0}, 32'd0);
        chk("async_rst_inst1", {12'd0, inst1}, 32'd0);
        chk("async_rst_busy1", {31'd0, busy1}, 32'd0);
        start = 1'b1; host_inst = 20'hABCDE;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_hold_inst", {12'd0, inst0}, 32'd0);
        chk("rst_hold_busy", {31'd0, busy1}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 20'h5A5A5, 1'b1);
        @(posedge clk); #2;
        chk("post_rst_passthru", {12'd0, inst1}, 32'h5A5A5);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 20'($urandom), 1'b1);
        repeat (2) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
